// File: rtl/kernel_ap_ctrl_launcher.sv
// Bridges a valid/ready argument stream to a block-level ap_ctrl kernel,
// keeping one invocation in flight and returning its result as a valid/ready token.
//
// state | meaning
// IDLE  | no invocation in flight, ready for an argument token
// START | ap_start held with stable ap_args until the kernel accepts
// RUN   | kernel accepted, waiting for ap_done
// DONE  | result presented on outs_*, waiting for the consumer
module kernel_ap_ctrl_launcher #(
  parameter int ARG_WIDTH   = 16,
  parameter int RES_WIDTH   = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ARG_WIDTH-1:0]   ins_data,
  input  logic                   ins_valid,
  output logic                   ins_ready,
  output logic                   ap_start,
  output logic [ARG_WIDTH-1:0]   ap_args,
  input  logic                   ap_ready,
  input  logic                   ap_done,
  input  logic [RES_WIDTH-1:0]   ap_result,
  output logic [RES_WIDTH-1:0]   outs_data,
  output logic                   outs_valid,
  input  logic                   outs_ready,
  output logic [COUNT_WIDTH-1:0] launch_count,
  output logic                   proto_err
);

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t                 r_state;
  logic                   r_ap_start;
  logic [ARG_WIDTH-1:0]   r_ap_args;
  logic [RES_WIDTH-1:0]   r_outs_data;
  logic                   r_outs_valid;
  logic [COUNT_WIDTH-1:0] r_launch_count;
  logic                   r_proto_err;

  // Combinational from outs_ready so a finishing result and a new argument can
  // hand off in the same cycle.
  assign ins_ready    = (r_state == IDLE) || ((r_state == DONE) && outs_ready);
  assign ap_start     = r_ap_start;
  assign ap_args      = r_ap_args;
  assign outs_data    = r_outs_data;
  assign outs_valid   = r_outs_valid;
  assign launch_count = r_launch_count;
  assign proto_err    = r_proto_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_ap_start     <= 1'b0;
      r_ap_args      <= '0;
      r_outs_data    <= '0;
      r_outs_valid   <= 1'b0;
      r_launch_count <= '0;
      r_proto_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ap_done) r_proto_err <= 1'b1;
          if (ins_valid) begin
            r_ap_args  <= ins_data;
            r_ap_start <= 1'b1;
            r_state    <= START;
          end
        end
        START: begin
          // A done without acceptance belongs to no invocation of ours; drop it.
          if (ap_ready) begin
            r_ap_start <= 1'b0;
            if (ap_done) begin
              r_outs_data  <= ap_result;
              r_outs_valid <= 1'b1;
              r_state      <= DONE;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (ap_done) begin
            r_outs_data  <= ap_result;
            r_outs_valid <= 1'b1;
            r_state      <= DONE;
          end
        end
        DONE: begin
          if (ap_done) r_proto_err <= 1'b1;
          if (outs_ready) begin
            r_outs_valid   <= 1'b0;
            r_launch_count <= r_launch_count + 1'b1;
            if (ins_valid) begin
              r_ap_args  <= ins_data;
              r_ap_start <= 1'b1;
              r_state    <= START;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_ap_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_ap_ctrl_launcher.sv
// Randomized bench for kernel_ap_ctrl_launcher: a kernel model with random
// acceptance stalls and latencies, plus a scoreboard of expected result tokens.
module tb_kernel_ap_ctrl_launcher;
  localparam int AW = 16;
  localparam int RW = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] ins_data = '0;
  logic          ins_valid = 1'b0;
  logic          ins_ready;
  logic          ap_start;
  logic [AW-1:0] ap_args;
  logic          ap_ready;
  logic          ap_done;
  logic [RW-1:0] ap_result;
  logic [RW-1:0] outs_data;
  logic          outs_valid;
  logic          outs_ready = 1'b0;
  logic [CW-1:0] launch_count;
  logic          proto_err;

  // kernel side is driven either by the kernel model or by directed code
  logic          kern_en = 1'b0;
  logic          k_ready = 1'b0, k_done = 1'b0;
  logic [RW-1:0] k_result = '0;
  logic          d_ready = 1'b0, d_done = 1'b0;
  logic [RW-1:0] d_result = '0;
  assign ap_ready  = kern_en ? k_ready  : d_ready;
  assign ap_done   = kern_en ? k_done   : d_done;
  assign ap_result = kern_en ? k_result : d_result;

  kernel_ap_ctrl_launcher #(.ARG_WIDTH(AW), .RES_WIDTH(RW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .ins_data(ins_data), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ap_start(ap_start), .ap_args(ap_args),
    .ap_ready(ap_ready), .ap_done(ap_done), .ap_result(ap_result),
    .outs_data(outs_data), .outs_valid(outs_valid), .outs_ready(outs_ready),
    .launch_count(launch_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            failures = 0;
  bit            chk_en = 1'b0;
  bit            took = 1'b0;
  logic [RW-1:0] exp_q[$];
  logic [AW-1:0] last_acc = '0;
  logic [CW-1:0] exp_count = '0;
  logic          exp_perr = 1'b0;
  int            n_done = 0;

  // what the wrapped kernel computes from its arguments
  function automatic logic [RW-1:0] kfun(input logic [AW-1:0] a);
    return (a[15:8] ^ a[7:0]) + 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // kernel model: random acceptance stall (with stray done), random latency 0..4
  bit            k_pending = 1'b0, k_acc_prev = 1'b0, k_done_prev = 1'b0;
  int            k_lat = 0;
  logic [RW-1:0] k_res = '0;
  always @(negedge clk) begin
    if (!rst || !kern_en) begin
      k_pending = 0; k_acc_prev = 0; k_done_prev = 0; k_ready = 0; k_done = 0;
    end else begin
      if (k_acc_prev) chk("ap_start_drop", ap_start, 0);
      if (k_done_prev) begin
        chk("outs_valid_after_done", outs_valid, 1);
        chk("done_capture", outs_data, k_res);
      end
      k_acc_prev = 0; k_done_prev = 0;
      k_ready = 0; k_done = 0; k_result = RW'($urandom);
      if (k_pending) begin
        chk("start_while_busy", ap_start, 0);
        if (k_lat == 0) begin
          k_done = 1; k_result = k_res; k_pending = 0; k_done_prev = 1;
        end else k_lat--;
      end else if (ap_start) begin
        if ($urandom_range(0, 2) == 0) begin
          k_done = 1'($urandom_range(0, 1));
        end else begin
          k_ready = 1; k_acc_prev = 1;
          k_res = kfun(ap_args);
          k_lat = int'($urandom_range(0, 4));
          if (k_lat == 0) begin
            k_done = 1; k_result = k_res; k_done_prev = 1;
          end else begin
            k_pending = 1; k_lat--;
          end
        end
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      exp_count = '0;
    end else if (chk_en) begin
      chk("ap_args", ap_args, last_acc);
      chk("launch_count", launch_count, exp_count);
      chk("proto_err", proto_err, exp_perr);
      if (outs_valid) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_result actual=%0h required=none", outs_data);
        end else chk("outs_data", outs_data, exp_q[0]);
      end
      #2;
      if (outs_valid && outs_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        exp_count++;
        n_done++;
      end
    end
  end

  task automatic step(input int pv, input int pr);
    logic exp_rdy;
    @(negedge clk);
    if (took) ins_valid = 1'b0;
    if (!ins_valid && $urandom_range(0, 99) < pv) begin
      ins_valid = 1'b1;
      ins_data  = AW'($urandom);
    end
    outs_ready = ($urandom_range(0, 99) < pr);
    #1;
    exp_rdy = (exp_q.size() == 0) || (outs_valid && outs_ready);
    chk("ins_ready", ins_ready, exp_rdy);
    took = ins_valid && ins_ready;
    if (took) begin
      exp_q.push_back(kfun(ins_data));
      last_acc = ins_data;
    end
  endtask

  task automatic run_random(input int ncyc);
    for (int c = 0; c < ncyc; c++) step(int'($urandom_range(20, 90)), int'($urandom_range(20, 90)));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ins_valid) && n < 300) begin
      step(0, 100);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || ins_valid) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
  endtask

  initial begin
    #12;
    chk("rst_ap_start", ap_start, 0);
    chk("rst_ap_args", ap_args, 0);
    chk("rst_outs_data", outs_data, 0);
    chk("rst_outs_valid", outs_valid, 0);
    chk("rst_launch_count", launch_count, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_ins_ready", ins_ready, 1);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    kern_en = 1'b1;
    chk_en  = 1'b1;

    run_random(2500);
    drain();

    // stray done while idle
    kern_en = 1'b0;
    @(negedge clk); d_done = 1'b1; d_result = 8'hFF;
    #1 exp_perr = 1'b1;
    @(negedge clk); d_done = 1'b0;
    #1;
    chk("spurious_outs_valid", outs_valid, 0);
    chk("spurious_ins_ready", ins_ready, 1);
    kern_en = 1'b1;
    run_random(300);
    drain();

    // asynchronous reset while the kernel is running
    kern_en = 1'b0;
    chk_en  = 1'b0;
    took    = 1'b0;
    @(negedge clk); ins_valid = 1'b1; ins_data = 16'hBEEF; outs_ready = 1'b0;
    @(negedge clk); ins_valid = 1'b0; d_ready = 1'b1;
    chk("mr_start", ap_start, 1);
    chk("mr_args", ap_args, 16'hBEEF);
    @(negedge clk); d_ready = 1'b0;
    chk("mr_run_start_low", ap_start, 0);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("mr_ap_start", ap_start, 0);
    chk("mr_outs_valid", outs_valid, 0);
    chk("mr_launch_count", launch_count, 0);
    chk("mr_proto_err", proto_err, 0);
    chk("mr_ins_ready", ins_ready, 1);
    last_acc = '0;
    exp_perr = 1'b0;
    @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    kern_en = 1'b1;
    chk_en  = 1'b1;
    run_random(300);
    drain();
    chk("completed_enough", (n_done > 100) ? 1 : 0, 1);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
